// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the 32-bit word and the memory arbiter state encoding.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DBUSY = 2'd1,
    IBUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the memory arbiter's request, hit and RAM-side signals.
// Modport ma is the arbiter's view; modport tb is the requester/RAM view.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  ihit;
  logic  dhit;
  word_t imemload;
  word_t dmemload;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ramready;

  modport ma (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  ramload, ramready,
    output ihit, dhit, imemload, dmemload,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport tb (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    output ramload, ramready,
    input  ihit, dhit, imemload, dmemload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/memory_arbiter.sv
// Memory arbiter: serves instruction fetches and data reads/writes on a
// single-ported RAM, one access at a time, with one-cycle hit pulses.
// Data normally has priority; defining MEM_ARB_FAIR_EN adds a counter that
// forces an instruction grant after FAIR_LIMIT consecutive data grants made
// while a fetch was waiting.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight; strobes low; arbitrate at end of cycle
// DBUSY | data access in flight from latched addr/store/op
// IBUSY | instruction fetch in flight from latched addr
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int FAIR_LIMIT = 4
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  input  logic  dmemREN,
  input  logic  dmemWEN,
  input  word_t dmemaddr,
  input  word_t dmemstore,
  output logic  ihit,
  output logic  dhit,
  output word_t imemload,
  output word_t dmemload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ramready
);

  arb_state_t state_q, state_d;
  word_t      addr_q, addr_d;
  word_t      store_q, store_d;
  logic       write_q, write_d;
  logic       grant_i, grant_d;
  logic       force_i;
  logic       d_owner;

  // The data access stays alive only while the request that started it is held.
  assign d_owner = write_q ? dmemWEN : dmemREN;

`ifdef MEM_ARB_FAIR_EN
  localparam int FAIR_W = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);

  logic [FAIR_W-1:0] fair_cnt_q, fair_cnt_d;

  // Fetch is forced once the data side has used up its run of grants.
  assign force_i = imemREN && (fair_cnt_q >= FAIR_W'(FAIR_LIMIT));

  // Saturating run length of data grants taken over a waiting fetch.
  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (grant_i) begin
      fair_cnt_d = '0;
    end else if (grant_d) begin
      if (!imemREN) begin
        fair_cnt_d = '0;
      end else if (fair_cnt_q < FAIR_W'(FAIR_LIMIT)) begin
        fair_cnt_d = fair_cnt_q + 1'b1;
      end
    end
  end

  // Fairness counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fair_cnt_q <= '0;
    end else begin
      fair_cnt_q <= fair_cnt_d;
    end
  end
`else
  logic [31:0] fair_limit_unused;
  assign fair_limit_unused = 32'(FAIR_LIMIT);
  assign force_i = 1'b0;
`endif

  // Arbitration, latching of the granted request, and completion/abort.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    write_d = write_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (force_i) begin
          grant_i = 1'b1;
        end else if (dmemREN || dmemWEN) begin
          grant_d = 1'b1;
        end else if (imemREN) begin
          grant_i = 1'b1;
        end
        if (grant_d) begin
          state_d = DBUSY;
          addr_d  = dmemaddr;
          store_d = dmemstore;
          write_d = dmemWEN;
        end else if (grant_i) begin
          state_d = IBUSY;
          addr_d  = imemaddr;
          write_d = 1'b0;
        end
      end
      DBUSY: begin
        if (ramready || !d_owner) begin
          state_d = IDLE;
        end
      end
      IBUSY: begin
        if (ramready || !imemREN) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      write_q <= write_d;
    end
  end

  // RAM side is driven purely from registered state, so strobes drop the
  // cycle after an abort and address/data hold their values while idle.
  always_comb begin
    ramREN   = (state_q == IBUSY) || ((state_q == DBUSY) && !write_q);
    ramWEN   = (state_q == DBUSY) && write_q;
    ramaddr  = addr_q;
    ramstore = store_q;
  end

  // Hits and load data follow ramready combinationally in the busy cycle.
  always_comb begin
    ihit     = (state_q == IBUSY) && ramready;
    dhit     = (state_q == DBUSY) && ramready;
    imemload = ihit ? ramload : '0;
    dmemload = (dhit && !write_q) ? ramload : '0;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus a
// randomized transaction run against a word-addressed reference memory.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int TB_FAIR_LIMIT = 2;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR_EN = 1'b1;
`else
  localparam bit FAIR_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  word_t ref_mem [word_t];

  memory_arbiter_if mif ();

  memory_arbiter #(.FAIR_LIMIT(TB_FAIR_LIMIT)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (mif.imemREN),
    .imemaddr (mif.imemaddr),
    .dmemREN  (mif.dmemREN),
    .dmemWEN  (mif.dmemWEN),
    .dmemaddr (mif.dmemaddr),
    .dmemstore(mif.dmemstore),
    .ihit     (mif.ihit),
    .dhit     (mif.dhit),
    .imemload (mif.imemload),
    .dmemload (mif.dmemload),
    .ramREN   (mif.ramREN),
    .ramWEN   (mif.ramWEN),
    .ramaddr  (mif.ramaddr),
    .ramstore (mif.ramstore),
    .ramload  (mif.ramload),
    .ramready (mif.ramready)
  );

  always #5 CLK = ~CLK;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    mif.imemREN   = 1'b0;
    mif.dmemREN   = 1'b0;
    mif.dmemWEN   = 1'b0;
    mif.ramready  = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    mif.imemaddr = 32'h0; mif.dmemaddr = 32'h0; mif.dmemstore = 32'h0; mif.ramload = 32'h0;
    nRST = 1'b0;
    #2;
    n_tests++;
    if ({mif.ihit, mif.dhit, mif.ramREN, mif.ramWEN} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0000", {mif.ihit, mif.dhit, mif.ramREN, mif.ramWEN});
    end
    n_tests++;
    if (mif.ramaddr !== 32'h0 || mif.ramstore !== 32'h0) begin
      n_fail++; $display("FAIL reset_latches: got addr %h store %h want 0", mif.ramaddr, mif.ramstore);
    end
    next_cycle();
    nRST = 1'b1;
    mif.dmemWEN = 1'b1; mif.dmemaddr = 32'h60; mif.dmemstore = 32'hABCD;
    next_cycle();
    #1;
    n_tests++;
    if (mif.ramWEN !== 1'b1 || mif.ramaddr !== 32'h60) begin
      n_fail++; $display("FAIL reset_pre_busy: got wen %b addr %h want 1 60", mif.ramWEN, mif.ramaddr);
    end
    nRST = 1'b0;
    #1;
    n_tests++;
    if ({mif.ramREN, mif.ramWEN, mif.dhit} !== 3'b000 || mif.ramaddr !== 32'h0 || mif.ramstore !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_busy: got ren %b wen %b addr %h store %h want all 0",
                         mif.ramREN, mif.ramWEN, mif.ramaddr, mif.ramstore);
    end
    next_cycle();
    nRST = 1'b1;
    drive_idle();
    #1;
    n_tests++;
    if ({mif.ramREN, mif.ramWEN, mif.ihit, mif.dhit} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_idle_after: got %b want 0000", {mif.ramREN, mif.ramWEN, mif.ihit, mif.dhit});
    end
    next_cycle();
    mif.ramready = 1'b1;
    #1;
    n_tests++;
    if ({mif.ramREN, mif.ramWEN, mif.ihit, mif.dhit} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_idle_ready: got %b want 0000", {mif.ramREN, mif.ramWEN, mif.ihit, mif.dhit});
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_single_read();
    next_cycle();
    mif.dmemREN = 1'b1; mif.dmemaddr = 32'h40; mif.ramready = 1'b0;
    #1;
    n_tests++;
    if (mif.ramREN !== 1'b0 || mif.dhit !== 1'b0) begin
      n_fail++; $display("FAIL read_c0: got ren %b dhit %b want 0 0", mif.ramREN, mif.dhit);
    end
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      mif.ramready = (c == 2);
      mif.ramload = (c == 2) ? 32'hDEADBEEF : 32'h0;
      #1;
      n_tests++;
      if (mif.ramREN !== 1'b1 || mif.ramWEN !== 1'b0 || mif.ramaddr !== 32'h40 || mif.dhit !== (c == 2)) begin
        n_fail++; $display("FAIL read_busy c%0d: got ren %b wen %b addr %h dhit %b want 1 0 40 %0d",
                           c, mif.ramREN, mif.ramWEN, mif.ramaddr, mif.dhit, (c == 2));
      end
    end
    n_tests++;
    if (mif.dmemload !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL read_data: got %h want deadbeef", mif.dmemload);
    end
    next_cycle();
    drive_idle();
    #1;
    n_tests++;
    if (mif.ramREN !== 1'b0 || mif.dhit !== 1'b0 || mif.ramaddr !== 32'h40) begin
      n_fail++; $display("FAIL read_idle: got ren %b dhit %b addr %h want 0 0 40", mif.ramREN, mif.dhit, mif.ramaddr);
    end
  endtask

  task automatic test_priority();
    next_cycle();
    mif.imemREN = 1'b1; mif.imemaddr = 32'h100;
    mif.dmemWEN = 1'b1; mif.dmemaddr = 32'h80; mif.dmemstore = 32'h1234;
    mif.ramready = 1'b0;
    #1;
    next_cycle();
    mif.dmemaddr = 32'hFFC; mif.dmemstore = 32'h5555;
    mif.ramready = 1'b1;
    #1;
    n_tests++;
    if ({mif.ramWEN, mif.ramREN} !== 2'b10 || mif.ramaddr !== 32'h80 || mif.ramstore !== 32'h1234) begin
      n_fail++; $display("FAIL prio_write: got wen %b ren %b addr %h store %h want 1 0 80 1234",
                         mif.ramWEN, mif.ramREN, mif.ramaddr, mif.ramstore);
    end
    n_tests++;
    if ({mif.dhit, mif.ihit} !== 2'b10) begin
      n_fail++; $display("FAIL prio_dhit: got dhit %b ihit %b want 1 0", mif.dhit, mif.ihit);
    end
    next_cycle();
    mif.dmemWEN = 1'b0; mif.ramready = 1'b0;
    #1;
    n_tests++;
    if ({mif.ramWEN, mif.ramREN, mif.ihit, mif.dhit} !== 4'b0000) begin
      n_fail++; $display("FAIL prio_gap: got %b want 0000", {mif.ramWEN, mif.ramREN, mif.ihit, mif.dhit});
    end
    next_cycle();
    mif.ramready = 1'b1; mif.ramload = 32'hCAFEF00D;
    #1;
    n_tests++;
    if ({mif.ramREN, mif.ihit, mif.dhit} !== 3'b110 || mif.ramaddr !== 32'h100 || mif.imemload !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL prio_ihit: got ren %b ihit %b dhit %b addr %h load %h want 1 1 0 100 cafef00d",
                         mif.ramREN, mif.ihit, mif.dhit, mif.ramaddr, mif.imemload);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_abort();
    next_cycle();
    mif.imemREN = 1'b1; mif.imemaddr = 32'h200; mif.ramready = 1'b0;
    next_cycle();
    #1;
    n_tests++;
    if (mif.ramREN !== 1'b1 || mif.ramaddr !== 32'h200) begin
      n_fail++; $display("FAIL abort_busy: got ren %b addr %h want 1 200", mif.ramREN, mif.ramaddr);
    end
    next_cycle();
    mif.imemREN = 1'b0;
    #1;
    n_tests++;
    if (mif.ramREN !== 1'b1 || mif.ihit !== 1'b0) begin
      n_fail++; $display("FAIL abort_drop: got ren %b ihit %b want 1 0", mif.ramREN, mif.ihit);
    end
    next_cycle();
    mif.ramready = 1'b1;
    #1;
    n_tests++;
    if ({mif.ramREN, mif.ramWEN, mif.ihit, mif.dhit} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_after: got %b want 0000", {mif.ramREN, mif.ramWEN, mif.ihit, mif.dhit});
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_immediate_ready();
    word_t ld;
    next_cycle();
    mif.imemREN = 1'b1; mif.imemaddr = 32'h300; mif.ramready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) next_cycle();
      ld = $urandom;
      mif.ramload = ld;
      #1;
      n_tests++;
      if (mif.ihit !== (k % 2 == 1) || mif.dhit !== 1'b0) begin
        n_fail++; $display("FAIL imm_pattern k%0d: got ihit %b dhit %b want %0d 0", k, mif.ihit, mif.dhit, (k % 2 == 1));
      end
      if (k % 2 == 1) begin
        n_tests++;
        if (mif.imemload !== ld) begin
          n_fail++; $display("FAIL imm_load k%0d: got %h want %h", k, mif.imemload, ld);
        end
      end
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_fairness();
    byte got [$];
    byte exp [$];
    int  cnt = 0;
    nRST = 1'b0;
    drive_idle();
    next_cycle();
    nRST = 1'b1;
    mif.imemREN = 1'b1; mif.imemaddr = 32'h400;
    mif.dmemREN = 1'b1; mif.dmemaddr = 32'h500;
    mif.ramready = 1'b1;
    for (int g = 0; g < 6; g++) begin
      if (FAIR_EN && cnt >= TB_FAIR_LIMIT) begin
        exp.push_back("I"); cnt = 0;
      end else begin
        exp.push_back("D"); cnt = (cnt < TB_FAIR_LIMIT) ? cnt + 1 : cnt;
      end
    end
    for (int c = 0; c < 30 && got.size() < 6; c++) begin
      next_cycle();
      mif.ramload = $urandom;
      #1;
      if (mif.ihit && mif.dhit) begin
        n_tests++; n_fail++; $display("FAIL fair_both_hits: got ihit 1 dhit 1 want at most one");
      end
      if (mif.ihit) got.push_back("I");
      else if (mif.dhit) got.push_back("D");
    end
    n_tests++;
    if (got.size() !== 6) begin
      n_fail++; $display("FAIL fair_count: got %0d grants want 6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== exp[i]) begin
        n_fail++; $display("FAIL fair_order g%0d: got %s want %s", i, string'(got[i]), string'(exp[i]));
      end
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_random();
    int    kind, lat;
    word_t a, d, expld;
    logic  is_wr, is_i;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(3);
      lat  = $urandom_range(3);
      a    = word_t'($urandom_range(3)) << 2;
      d    = $urandom;
      is_i  = (kind == 0);
      is_wr = (kind >= 2);
      expld = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
      next_cycle();
      mif.imemREN = is_i; mif.imemaddr = a;
      mif.dmemREN = (kind == 1) || (kind == 3);
      mif.dmemWEN = is_wr; mif.dmemaddr = a; mif.dmemstore = d;
      mif.ramready = 1'b0;
      #1;
      n_tests++;
      if ({mif.ramREN, mif.ramWEN, mif.ihit, mif.dhit} !== 4'b0000) begin
        n_fail++; $display("FAIL rnd_idle t%0d: got %b want 0000", t, {mif.ramREN, mif.ramWEN, mif.ihit, mif.dhit});
      end
      for (int b = 1; b <= lat + 1; b++) begin
        next_cycle();
        mif.ramready = (b == lat + 1);
        mif.ramload  = is_wr ? word_t'($urandom) : expld;
        #1;
        n_tests++;
        if (mif.ramREN !== !is_wr || mif.ramWEN !== is_wr || mif.ramaddr !== a ||
            (is_wr && mif.ramstore !== d)) begin
          n_fail++; $display("FAIL rnd_ram t%0d b%0d: got ren %b wen %b addr %h store %h want %b %b %h %h",
                             t, b, mif.ramREN, mif.ramWEN, mif.ramaddr, mif.ramstore, !is_wr, is_wr, a, d);
        end
        n_tests++;
        if (mif.ihit !== (is_i && b == lat + 1) || mif.dhit !== (!is_i && b == lat + 1)) begin
          n_fail++; $display("FAIL rnd_hit t%0d b%0d: got ihit %b dhit %b want %0d %0d",
                             t, b, mif.ihit, mif.dhit, (is_i && b == lat + 1), (!is_i && b == lat + 1));
        end
      end
      if (!is_wr) begin
        n_tests++;
        if ((is_i ? mif.imemload : mif.dmemload) !== expld) begin
          n_fail++; $display("FAIL rnd_load t%0d: got %h want %h", t, (is_i ? mif.imemload : mif.dmemload), expld);
        end
      end else begin
        ref_mem[a] = d;
      end
      next_cycle();
      drive_idle();
      mif.ramready = 1'($urandom_range(1));
      #1;
      n_tests++;
      if ({mif.ramREN, mif.ramWEN, mif.ihit, mif.dhit} !== 4'b0000) begin
        n_fail++; $display("FAIL rnd_gap t%0d: got %b want 0000", t, {mif.ramREN, mif.ramWEN, mif.ihit, mif.dhit});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_priority();
    test_abort();
    test_immediate_ready();
    test_fairness();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
